// File: rtl/prewish_pkg.sv
// prewish_pkg: shared definitions for the prewish_loader front end.
//   state_t            - debounce FSM state encoding (2 bits)
//   DEFAULT_DATA_WIDTH - default DIP / mask width
package prewish_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        DOWN     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/prewish_if.sv
// prewish_if: load-strobe bus from prewish_loader to the mentor.
//   stb - one-cycle load strobe (drives mentor STB_I)
//   dat - latched mask, held between strobes (drives mentor DAT_I)
// No back-pressure: the receiver must accept every strobe.
interface prewish_if
    import prewish_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  stb;
    logic [DATA_WIDTH-1:0] dat;

    modport master (output stb, output dat);
    modport slave  (input  stb, input  dat);

endinterface

// File: rtl/prewish_sync.sv
// prewish_sync: parameterised-width two-flop synchroniser.
//   clk     - destination clock
//   rst_n   - asynchronous active-low reset, loads RST_VAL into both stages
//   d       - asynchronous input
//   q       - synchronised output (2 cycles latency)
module prewish_sync #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/prewish_loader.sv
// prewish_loader: DIP-switch / load-button front end for the mentor chain.
// Debounces an active-low button; each debounced press-and-release issues a
// one-cycle strobe carrying the DIP value sampled at release completion.
//   CLK_I     - system clock (rising edge)
//   RST_I     - asynchronous active-low reset
//   i_btn     - raw button, active-low, asynchronous
//   i_dip     - raw DIP switches, asynchronous
//   bus       - master side of prewish_if (stb = STB_O, dat = DAT_O)
//   o_pressed - debounced button level (1 = pressed)
module prewish_loader
    import prewish_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  i_btn,
    input  logic [DATA_WIDTH-1:0] i_dip,
    prewish_if.master             bus,
    output logic                  o_pressed
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = 1;

    logic                     btn_sync;
    logic                     btn_s;
    logic [DATA_WIDTH-1:0]    dip_s;

    state_t                   state, state_next;
    logic [DEBOUNCE_BITS-1:0] cnt, cnt_next;
    logic                     strobe_next;
    logic                     capture;

    // Button synchroniser resets to "released" so reset never fakes a press.
    prewish_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_btn_sync (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .d     (i_btn),
        .q     (btn_sync)
    );

    prewish_sync #(
        .WIDTH   (DATA_WIDTH),
        .RST_VAL ('0)
    ) u_dip_sync (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .d     (i_dip),
        .q     (dip_s)
    );

    assign btn_s = ~btn_sync;

    // Counter only runs in the two debounce states; any move or any return
    // of btn_s to the opposite level restarts it, and reaching all-ones
    // always leaves the state, so it never wraps.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CNT_ONE;
        strobe_next = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_s) state_next = PRESS_DB;
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '1) begin
                    state_next = DOWN;
                    cnt_next   = '0;
                end
            end
            DOWN: begin
                cnt_next = '0;
                if (!btn_s) state_next = REL_DB;
            end
            REL_DB: begin
                if (btn_s) begin
                    state_next = DOWN;
                    cnt_next   = '0;
                end else if (cnt == '1) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    strobe_next = 1'b1;
                    capture     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state   <= IDLE;
            cnt     <= '0;
            bus.stb <= 1'b0;
            bus.dat <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bus.stb <= strobe_next;
            if (capture) bus.dat <= dip_s;
        end
    end

    assign o_pressed = (state == DOWN) || (state == REL_DB);

endmodule
